// File: rtl/lif_network_param.sv
// Purpose : N_IN leaky integrate-and-fire input neurons drive one LIF output neuron via runtime-writable weights.
// Latency : input spike -> syn_current 1 edge -> out_spike at the following edge at the earliest.
// Backpressure: none; the network advances every clock and cannot be stalled.
//
// Ports:
//   clk, reset (async, active-low)
//   ext_in      packed per-neuron input currents, neuron i on [i*W +: W]
//   cfg_we/cfg_addr/cfg_wdata  weight write port; out-of-range addresses are dropped
//   spike       registered input-neuron spikes (single-cycle pulses)
//   out_spike   registered output-neuron spike
//   out_mem     output-neuron membrane
//   syn_current registered, saturated weighted sum of input spikes
//   spike_count saturating count of out_spike pulses (only with LIF_SPIKE_COUNT_EN)
//
// Build option: define LIF_SPIKE_COUNT_EN to add the spike_count port and counter.
module lif_network_param #(
    parameter int N_IN        = 3,
    parameter int W           = 8,
    parameter int THRESH      = 16,
    parameter int LEAK_SHIFT  = 2,
    parameter int REFRAC      = 2,
    parameter int WEIGHT_INIT = 6,
    localparam int AW         = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_IN*W-1:0]   ext_in,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [W-1:0]        cfg_wdata,
    output logic [N_IN-1:0]     spike,
    output logic                out_spike,
    output logic [W-1:0]        out_mem,
    output logic [W-1:0]        syn_current
`ifdef LIF_SPIKE_COUNT_EN
    ,
    output logic [15:0]         spike_count
`endif
);

    // Refractory counter must hold REFRAC; keep at least one bit when REFRAC is 0.
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    // Synapse accumulator is wide enough for N_IN full-scale weights.
    localparam int SW = W + $clog2(N_IN + 1);

    localparam logic [W:0]    TH = (W + 1)'(THRESH);
    localparam logic [RW-1:0] RF = RW'(REFRAC);

    typedef struct packed {
        logic [W-1:0]  mem;
        logic [RW-1:0] cnt;
        logic          spk;
    } nstate_t;

    // One LIF step shared by every neuron in the network.
    function automatic nstate_t lif_step(input nstate_t s, input logic [W-1:0] cur);
        nstate_t    n;
        logic [W:0] sum;
        n   = s;
        // mem - (mem >> k) never underflows, so the extra bit only catches the cur overflow.
        sum = {1'b0, s.mem} - {1'b0, s.mem >> LEAK_SHIFT} + {1'b0, cur};
        if (s.cnt != '0) begin
            n.cnt = s.cnt - RW'(1);
            n.mem = '0;
            n.spk = 1'b0;
        end else if (sum >= TH) begin
            n.spk = 1'b1;
            n.mem = '0;
            n.cnt = RF;
        end else begin
            n.spk = 1'b0;
            n.mem = sum[W] ? '1 : sum[W-1:0];
        end
        return n;
    endfunction

    nstate_t       in_st  [N_IN];
    nstate_t       in_nxt [N_IN];
    nstate_t       out_st;
    nstate_t       out_nxt;
    logic [W-1:0]  weight [N_IN];
    logic [SW-1:0] syn_sum;
    logic [W-1:0]  syn_nxt;

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            in_nxt[i] = lif_step(in_st[i], ext_in[i*W +: W]);
            spike[i]  = in_st[i].spk;
        end
        out_nxt   = lif_step(out_st, syn_current);
        out_spike = out_st.spk;
        out_mem   = out_st.mem;
    end

    // Weighted spike sum uses the weights as they stand before this edge,
    // so a write coincident with a spike only takes effect next time.
    always_comb begin
        syn_sum = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (in_st[i].spk) begin
                syn_sum = syn_sum + SW'(weight[i]);
            end
        end
        syn_nxt = (|syn_sum[SW-1:W]) ? '1 : syn_sum[W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_IN; i++) begin
                in_st[i]  <= '0;
                weight[i] <= W'(WEIGHT_INIT);
            end
            out_st      <= '0;
            syn_current <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                in_st[i] <= in_nxt[i];
                // Addresses >= N_IN never match an index and are silently dropped.
                if (cfg_we && (cfg_addr == AW'(i))) begin
                    weight[i] <= cfg_wdata;
                end
            end
            out_st      <= out_nxt;
            syn_current <= syn_nxt;
        end
    end

`ifdef LIF_SPIKE_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spike_count <= '0;
        end else if (out_st.spk && (spike_count != 16'hFFFF)) begin
            spike_count <= spike_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lif_network_param.sv
// Directed bench for lif_network_param with default parameters.
// Edges are counted from each reset release; expected values are hand-traced LIF steps.
module tb_lif_network_param;

    localparam int N_IN = 3;
    localparam int W    = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [N_IN*W-1:0]   ext_in;
    logic                cfg_we;
    logic [1:0]          cfg_addr;
    logic [W-1:0]        cfg_wdata;
    logic [N_IN-1:0]     spike;
    logic                out_spike;
    logic [W-1:0]        out_mem;
    logic [W-1:0]        syn_current;
`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0]         spike_count;
`endif

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    lif_network_param dut (
        .clk         (clk),
        .reset       (reset),
        .ext_in      (ext_in),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .spike       (spike),
        .out_spike   (out_spike),
        .out_mem     (out_mem),
        .syn_current (syn_current)
`ifdef LIF_SPIKE_COUNT_EN
        ,
        .spike_count (spike_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic tick_to(input int e);
        while (edge_n < e) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_spike"},     32'(spike),       32'd0);
        check({tag, "_out_spike"}, 32'(out_spike),   32'd0);
        check({tag, "_out_mem"},   32'(out_mem),     32'd0);
        check({tag, "_syn"},       32'(syn_current), 32'd0);
`ifdef LIF_SPIKE_COUNT_EN
        check({tag, "_count"},     32'(spike_count), 32'd0);
`endif
    endtask

    // Called just after an edge: asserts reset between edges, checks, releases on the negedge.
    task automatic pulse_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check_zero(tag);
        @(negedge clk);
        reset  = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        reset     = 1'b0;
        ext_in    = '0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        #12;
        check_zero("rst");

        // Neuron0 driven with 8: mem 8, 14, then 19 >= 16 fires; period 5 with REFRAC=2.
        ext_in = {8'd0, 8'd0, 8'd8};
        @(negedge clk);
        reset  = 1'b1;
        edge_n = 0;

        tick_to(1);  check("a_e1_spike", 32'(spike), 32'd0);
        tick_to(2);  check("a_e2_spike", 32'(spike), 32'd0);
        tick_to(3);  check("a_e3_spike", 32'(spike), 32'b001);
                     check("a_e3_syn", 32'(syn_current), 32'd0);
        tick_to(4);  check("a_e4_spike", 32'(spike), 32'd0);
                     check("a_e4_syn", 32'(syn_current), 32'd6);
        tick_to(5);  check("a_e5_syn", 32'(syn_current), 32'd0);
                     check("a_e5_out_mem", 32'(out_mem), 32'd6);
        tick_to(6);  check("a_e6_out_mem", 32'(out_mem), 32'd5);
        tick_to(7);  check("a_e7_spike", 32'(spike), 32'd0);
        tick_to(8);  check("a_e8_spike", 32'(spike), 32'b001);
        tick_to(9);  check("a_e9_syn", 32'(syn_current), 32'd6);
        tick_to(10); check("a_e10_out_mem", 32'(out_mem), 32'd9);
                     check("a_e10_out_spike", 32'(out_spike), 32'd0);
        tick_to(13); check("a_e13_spike", 32'(spike), 32'b001);
        tick_to(15); check("a_e15_out_mem", 32'(out_mem), 32'd9);
                     check("a_e15_out_spike", 32'(out_spike), 32'd0);

        // Weight0 -> 20: next spike gives syn 20 and out_spike two edges after the spike.
        wr(2'd0, 8'd20);
        tick_to(16); cfg_we = 1'b0;
        tick_to(18); check("b_e18_spike", 32'(spike), 32'b001);
        tick_to(19); check("b_e19_syn", 32'(syn_current), 32'd20);
                     check("b_e19_out_mem", 32'(out_mem), 32'd4);
        tick_to(20); check("b_e20_out_spike", 32'(out_spike), 32'd1);
                     check("b_e20_out_mem", 32'(out_mem), 32'd0);
        tick_to(21); check("b_e21_out_spike", 32'(out_spike), 32'd0);
        tick_to(23); check("b_e23_spike", 32'(spike), 32'b001);
        // Write coincident with the spike: this cycle still uses weight 20.
        wr(2'd0, 8'd3);
        tick_to(24); cfg_we = 1'b0;
                     check("b_e24_syn_old_w", 32'(syn_current), 32'd20);
        tick_to(25); check("b_e25_out_spike", 32'(out_spike), 32'd1);
        tick_to(29); check("b_e29_syn_new_w", 32'(syn_current), 32'd3);

        // All weights 255, all inputs 255: simultaneous spikes, saturated synapse.
        ext_in = '0;
        pulse_reset("rst_c");
        wr(2'd0, 8'd255); tick_to(1);
        wr(2'd1, 8'd255); tick_to(2);
        wr(2'd2, 8'd255); tick_to(3);
        cfg_we = 1'b0;
        ext_in = {8'd255, 8'd255, 8'd255};
        tick_to(4);  check("c_e4_spike", 32'(spike), 32'b111);
        tick_to(5);  check("c_e5_syn_sat", 32'(syn_current), 32'd255);
                     check("c_e5_spike", 32'(spike), 32'd0);
        tick_to(6);  check("c_e6_out_spike", 32'(out_spike), 32'd1);
        tick_to(7);  check("c_e7_spike", 32'(spike), 32'b111);
        wr(2'd0, 8'd10); tick_to(8);
                     check("c_e8_syn_sat", 32'(syn_current), 32'd255);
        wr(2'd1, 8'd20); tick_to(9);
        wr(2'd2, 8'd30); tick_to(10);
                     check("c_e10_spike", 32'(spike), 32'b111);
        wr(2'd3, 8'd0);  tick_to(11);
        cfg_we = 1'b0;
                     check("c_e11_syn", 32'(syn_current), 32'd60);
        tick_to(12); check("c_e12_syn", 32'(syn_current), 32'd0);
        tick_to(14); check("c_e14_syn_bad_addr", 32'(syn_current), 32'd60);

        // Reset while the input neurons are refractory and weights are modified.
        pulse_reset("rst_d");
        tick_to(1);  check("d_e1_spike", 32'(spike), 32'b111);
        tick_to(2);  check("d_e2_syn_init_w", 32'(syn_current), 32'd18);
        tick_to(3);  check("d_e3_out_spike", 32'(out_spike), 32'd1);
`ifdef LIF_SPIKE_COUNT_EN
                     check("d_e3_count", 32'(spike_count), 32'd0);
`endif
        tick_to(4);
`ifdef LIF_SPIKE_COUNT_EN
                     check("d_e4_count", 32'(spike_count), 32'd1);
`endif
                     check("d_e4_out_spike", 32'(out_spike), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
